// File: rtl/obstacle_pkg.sv
// Shared types and screen constants for the obstacle engine and its sprite consumers.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } state_t;

  typedef enum logic [1:0] {
    KIND_FLOOR  = 2'b00,
    KIND_CEIL   = 2'b01,
    KIND_PORTAL = 2'b10
  } obs_kind_t;

  localparam logic [1:0]  GAME_NORMAL   = 2'b00;
  localparam logic [1:0]  GAME_INVERTED = 2'b01;
  localparam logic [10:0] FLOOR         = 11'd429;
  localparam logic [10:0] CEILING       = 11'd50;
  localparam logic [9:0]  SCREEN_X_MAX  = 10'd639;

  // Floor spikes get half the random draws; ceiling spikes and portals a quarter each.
  function automatic obs_kind_t kind_from_lfsr(input logic [1:0] r);
    obs_kind_t k;
    unique case (r)
      2'b10:   k = KIND_CEIL;
      2'b11:   k = KIND_PORTAL;
      default: k = KIND_FLOOR;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), free-running, reset to SEED.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/obstacle_engine.sv
// Obstacle world: spawns, scrolls and retires slots, detects player overlap, tracks score
// and the normal/inverted game mode.
module obstacle_engine
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_OBS     = 4,
  parameter int unsigned SCROLL_STEP = 4,
  parameter int unsigned OBS_W       = 16,
  parameter int unsigned OBS_H       = 24,
  parameter int unsigned SPAWN_MIN   = 40,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    startRandom,
  input  logic [9:0]              BallX,
  input  logic [9:0]              BallY,
  input  logic [9:0]              BallS,
  output logic                    collided,
  output logic [1:0]              game,
  output logic [NUM_OBS-1:0]      ObsValid,
  output logic [NUM_OBS*10-1:0]   ObsX,
  output logic [NUM_OBS*2-1:0]    ObsKind,
  output logic [15:0]             score
);

  localparam int unsigned SelW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

  state_t      state_q;
  logic [15:0] spawn_cnt_q;
  logic        collided_q;
  logic [1:0]  game_q;
  logic [15:0] score_q;
  logic [15:0] lfsr;

  logic [NUM_OBS-1:0] slot_valid;
  logic [NUM_OBS-1:0] spike_ov;
  logic [NUM_OBS-1:0] portal_ov;
  logic [NUM_OBS-1:0] score_hit;

  logic            spike_hit;
  logic            run_edge;
  logic            free_any;
  logic [SelW-1:0] spawn_sel;
  logic            spawn_en;
  logic [15:0]     cnt_dec;
  logic [15:0]     cnt_next;
  logic [16:0]     score_sum;
  logic [15:0]     score_next;
  logic [10:0]     px_lo, px_hi, py_lo, py_hi;
  logic            unused_lfsr;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .lfsr     (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:6];

  // Player box, low bounds clamped at 0.
  assign px_lo = (BallX >= BallS) ? {1'b0, BallX} - {1'b0, BallS} : 11'd0;
  assign px_hi = {1'b0, BallX} + {1'b0, BallS};
  assign py_lo = (BallY >= BallS) ? {1'b0, BallY} - {1'b0, BallS} : 11'd0;
  assign py_hi = {1'b0, BallY} + {1'b0, BallS};

  assign spike_hit = |spike_ov;
  assign run_edge  = (state_q == RUN) && !spike_hit;

  always_comb begin
    free_any  = 1'b0;
    spawn_sel = '0;
    for (int i = int'(NUM_OBS) - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_any  = 1'b1;
        spawn_sel = SelW'(i);
      end
    end
  end

  // The counter reaches zero on the SPAWN_MIN-th run edge, and that same edge spawns.
  always_comb begin
    cnt_dec  = (spawn_cnt_q == 16'd0) ? 16'd0 : spawn_cnt_q - 16'd1;
    spawn_en = run_edge && (cnt_dec == 16'd0) && free_any;
    cnt_next = spawn_en ? 16'(SPAWN_MIN) + {10'd0, lfsr[5:0]} : cnt_dec;
  end

  always_comb begin
    score_sum = {1'b0, score_q};
    for (int i = 0; i < int'(NUM_OBS); i++) begin
      score_sum = score_sum + 17'(score_hit[i]);
    end
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
    logic        valid_q;
    logic [9:0]  x_q;
    obs_kind_t   kind_q;
    logic        used_q;
    logic [10:0] ox_lo, ox_hi, y_lo, y_hi;
    logic        overlap, retire, is_spawn;

    always_comb begin
      y_lo = CEILING;
      y_hi = FLOOR;
      case (kind_q)
        KIND_FLOOR: begin
          y_lo = FLOOR - 11'(OBS_H);
          y_hi = FLOOR;
        end
        KIND_CEIL: begin
          y_lo = CEILING;
          y_hi = CEILING + 11'(OBS_H);
        end
        default: ;
      endcase
    end

    assign ox_lo    = {1'b0, x_q};
    assign ox_hi    = ox_lo + 11'(OBS_W - 1);
    assign overlap  = valid_q && (px_lo <= ox_hi) && (ox_lo <= px_hi) &&
                      (py_lo <= y_hi) && (y_lo <= py_hi);
    assign retire   = valid_q && (x_q < 10'(SCROLL_STEP));
    assign is_spawn = spawn_en && (spawn_sel == SelW'(g));

    assign slot_valid[g] = valid_q;
    assign spike_ov[g]   = overlap && (kind_q != KIND_PORTAL);
    assign portal_ov[g]  = overlap && (kind_q == KIND_PORTAL) && !used_q;
    assign score_hit[g]  = run_edge && retire && (kind_q != KIND_PORTAL);

    always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
        valid_q <= 1'b0;
        x_q     <= 10'd0;
        kind_q  <= KIND_FLOOR;
        used_q  <= 1'b0;
      end else if (run_edge) begin
        if (is_spawn) begin
          valid_q <= 1'b1;
          x_q     <= SCREEN_X_MAX;
          kind_q  <= kind_from_lfsr(lfsr[1:0]);
          used_q  <= 1'b0;
        end else if (valid_q) begin
          if (retire) begin
            valid_q <= 1'b0;
          end else begin
            x_q <= x_q - 10'(SCROLL_STEP);
          end
          if (portal_ov[g]) begin
            used_q <= 1'b1;
          end
        end
      end
    end

    assign ObsValid[g]          = valid_q;
    assign ObsX[g*10 +: 10]     = x_q;
    assign ObsKind[g*2 +: 2]    = kind_q;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      spawn_cnt_q <= 16'(SPAWN_MIN);
      collided_q  <= 1'b0;
      game_q      <= GAME_NORMAL;
      score_q     <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startRandom) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (spike_hit) begin
            // Spike beats any simultaneous portal; the world freezes here.
            collided_q <= 1'b1;
            state_q    <= DEAD;
          end else begin
            spawn_cnt_q <= cnt_next;
            score_q     <= score_next;
            game_q      <= game_q ^ {1'b0, ^portal_ov};
            if (!startRandom) begin
              state_q <= IDLE;
            end
          end
        end
        DEAD: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign collided = collided_q;
  assign game     = game_q;
  assign score    = score_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Randomized bench for obstacle_engine: two instances (default and SPAWN_MIN=1) checked
// every frame against a behavioural world model.
module tb_obstacle_engine;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       startRandom = 1'b0;
  logic [9:0] BallX = '0, BallY = '0, BallS = '0;
  logic [9:0] b_ball_x = 10'd1000, b_ball_y = 10'd300, b_ball_s = 10'd0;

  logic        a_coll, b_coll;
  logic [1:0]  a_game, b_game;
  logic [3:0]  a_valid, b_valid;
  logic [39:0] a_x, b_x;
  logic [7:0]  a_kind, b_kind;
  logic [15:0] a_score, b_score;

  obstacle_engine u_dut_a (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .startRandom(startRandom),
    .BallX      (BallX),
    .BallY      (BallY),
    .BallS      (BallS),
    .collided   (a_coll),
    .game       (a_game),
    .ObsValid   (a_valid),
    .ObsX       (a_x),
    .ObsKind    (a_kind),
    .score      (a_score)
  );

  obstacle_engine #(
    .SPAWN_MIN(1)
  ) u_dut_b (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .startRandom(startRandom),
    .BallX      (b_ball_x),
    .BallY      (b_ball_y),
    .BallS      (b_ball_s),
    .collided   (b_coll),
    .game       (b_game),
    .ObsValid   (b_valid),
    .ObsX       (b_x),
    .ObsKind    (b_kind),
    .score      (b_score)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // World model: mode 0 idle, 1 running, 2 dead. Kinds 0 floor, 1 ceiling, 2 portal.
  int          m_st[2];
  logic [15:0] m_lfsr[2];
  int          m_cnt[2];
  bit          m_valid[2][4];
  int          m_x[2][4];
  int          m_kind[2][4];
  bit          m_used[2][4];
  bit          m_coll[2];
  int          m_game[2];
  int          m_score[2];

  task automatic model_reset(input int d, input int spawn_min);
    m_st[d] = 0;
    m_lfsr[d] = 16'hACE1;
    m_cnt[d] = spawn_min;
    m_coll[d] = 0;
    m_game[d] = 0;
    m_score[d] = 0;
    for (int i = 0; i < 4; i++) begin
      m_valid[d][i] = 0;
      m_x[d][i] = 0;
      m_kind[d][i] = 0;
      m_used[d][i] = 0;
    end
  endtask

  function automatic bit touches(input int bx, input int by, input int bs, input int ox,
                                 input int kind);
    int pxl, pxh, pyl, pyh, yl, yh;
    pxl = (bx >= bs) ? bx - bs : 0;
    pxh = bx + bs;
    pyl = (by >= bs) ? by - bs : 0;
    pyh = by + bs;
    if (kind == 0) begin yl = 405; yh = 429; end
    else if (kind == 1) begin yl = 50; yh = 74; end
    else begin yl = 50; yh = 429; end
    return (pxl <= ox + 15) && (ox <= pxh) && (pyl <= yh) && (yl <= pyh);
  endfunction

  task automatic model_step(input int d, input int spawn_min, input bit start,
                            input int bx, input int by, input int bs);
    bit ov[4];
    bit spike;
    int free_slot, dec;
    logic [15:0] l;
    l = m_lfsr[d];
    if (m_st[d] == 0) begin
      if (start) m_st[d] = 1;
    end else if (m_st[d] == 1) begin
      spike = 0;
      for (int i = 0; i < 4; i++) begin
        ov[i] = m_valid[d][i] && touches(bx, by, bs, m_x[d][i], m_kind[d][i]);
        if (ov[i] && m_kind[d][i] != 2) spike = 1;
      end
      if (spike) begin
        m_coll[d] = 1;
        m_st[d] = 2;
      end else begin
        free_slot = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[d][i]) free_slot = i;
        for (int i = 0; i < 4; i++) begin
          if (m_valid[d][i]) begin
            if (ov[i] && m_kind[d][i] == 2 && !m_used[d][i]) begin
              m_used[d][i] = 1;
              m_game[d] ^= 1;
            end
            if (m_x[d][i] < 4) begin
              m_valid[d][i] = 0;
              if (m_kind[d][i] != 2 && m_score[d] < 65535) m_score[d]++;
            end else begin
              m_x[d][i] -= 4;
            end
          end
        end
        dec = (m_cnt[d] > 0) ? m_cnt[d] - 1 : 0;
        if (dec == 0 && free_slot >= 0) begin
          m_valid[d][free_slot] = 1;
          m_x[d][free_slot] = 639;
          m_kind[d][free_slot] = (l[1:0] == 2'b11) ? 2 : (l[1:0] == 2'b10) ? 1 : 0;
          m_used[d][free_slot] = 0;
          m_cnt[d] = spawn_min + int'(l[5:0]);
        end else begin
          m_cnt[d] = dec;
        end
        if (!start) m_st[d] = 0;
      end
    end
    m_lfsr[d] = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic compare_dut(input int d, input logic coll, input logic [1:0] gm,
                             input logic [3:0] vld, input logic [39:0] xs,
                             input logic [7:0] kd, input logic [15:0] sc);
    logic [3:0]  ev;
    logic [39:0] ex;
    logic [7:0]  ek;
    string p;
    p = (d == 0) ? "A" : "B";
    for (int i = 0; i < 4; i++) begin
      ev[i] = m_valid[d][i];
      ex[i*10 +: 10] = 10'(m_x[d][i]);
      ek[i*2 +: 2] = 2'(m_kind[d][i]);
    end
    check({p, ".collided"}, coll, m_coll[d]);
    check({p, ".game"}, gm, 2'(m_game[d]));
    check({p, ".ObsValid"}, vld, ev);
    check({p, ".ObsX"}, xs, ex);
    check({p, ".ObsKind"}, kd, ek);
    check({p, ".score"}, sc, 16'(m_score[d]));
  endtask

  task automatic compare_all();
    compare_dut(0, a_coll, a_game, a_valid, a_x, a_kind, a_score);
    compare_dut(1, b_coll, b_game, b_valid, b_x, b_kind, b_score);
  endtask

  task automatic tick();
    model_step(0, 40, startRandom, int'(BallX), int'(BallY), int'(BallS));
    model_step(1, 1, startRandom, int'(b_ball_x), int'(b_ball_y), int'(b_ball_s));
    @(posedge frame_clk);
    #1;
    compare_all();
  endtask

  task automatic park_ball();
    BallX = 10'd1000;
    BallY = 10'd300;
    BallS = 10'd0;
  endtask

  initial begin
    bit found;
    int hit_slot;

    // Reset asserted with no clock edge involved.
    #1 Reset = 1'b1;
    #2;
    model_reset(0, 40);
    model_reset(1, 1);
    compare_all();
    #9 Reset = 1'b0;

    // Idle: the world must not move while startRandom is low.
    for (int f = 0; f < 100; f++) begin
      BallX = 10'($urandom_range(0, 700));
      BallY = 10'($urandom_range(0, 479));
      BallS = 10'($urandom_range(0, 30));
      tick();
    end

    // First spawn lands on the 40th run edge, then scrolls.
    park_ball();
    startRandom = 1'b1;
    tick();
    for (int f = 1; f < 40; f++) tick();
    check("spawn.early_valid", a_valid[0], 1'b0);
    tick();
    check("spawn.valid", a_valid[0], 1'b1);
    check("spawn.x639", a_x[9:0], 10'd639);
    tick();
    check("spawn.x635", a_x[9:0], 10'd635);

    // Ball in the corridor: portals toggle, spikes pass and score, occasional pauses.
    for (int f = 0; f < 600; f++) begin
      startRandom = ($urandom_range(0, 19) != 0);
      BallX = 10'($urandom_range(0, 700));
      BallY = 10'd300;
      BallS = 10'($urandom_range(0, 12));
      tick();
    end

    // Steer the ball onto a spike the model knows is on screen.
    startRandom = 1'b1;
    park_ball();
    found = 0;
    hit_slot = 0;
    for (int f = 0; f < 2000 && !found; f++) begin
      for (int i = 0; i < 4; i++) begin
        if (!found && m_st[0] == 1 && m_valid[0][i] && m_kind[0][i] != 2 &&
            m_x[0][i] >= 100 && m_x[0][i] <= 500) begin
          found = 1;
          hit_slot = i;
        end
      end
      if (!found) tick();
    end
    check("hit.spike_found", found, 1'b1);
    if (found) begin
      BallX = 10'(m_x[0][hit_slot] + 8);
      BallY = (m_kind[0][hit_slot] == 0) ? 10'd429 : 10'd50;
      BallS = 10'd8;
      tick();
      check("hit.collided", a_coll, 1'b1);
    end

    // Dead state holds whatever the inputs do.
    for (int f = 0; f < 200; f++) begin
      startRandom = $urandom_range(0, 1) != 0;
      BallX = 10'($urandom_range(0, 700));
      BallY = 10'($urandom_range(0, 479));
      BallS = 10'($urandom_range(0, 20));
      tick();
    end
    check("dead.collided", a_coll, 1'b1);

    // Async reset between edges while B is still running.
    startRandom = 1'b1;
    for (int f = 0; f < 20; f++) tick();
    #2 Reset = 1'b1;
    #1;
    model_reset(0, 40);
    model_reset(1, 1);
    compare_all();
    #1 Reset = 1'b0;

    // Restart with a fully random ball.
    for (int f = 0; f < 120; f++) begin
      BallX = 10'($urandom_range(0, 700));
      BallY = 10'($urandom_range(0, 479));
      BallS = 10'($urandom_range(0, 16));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
